// File: rtl/uart_rx_ext.sv
// UART receiver: 2-FF synchroniser, 3-point majority sampling, configurable frame
// format, break detection and a first-word-fall-through output FIFO.
module uart_rx_ext #(
    parameter int CLK_DIV     = 234,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          parity_error,
    output logic                          frame_error,
    output logic                          break_det,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [TW-1:0] T_S0     = TW'(CLK_DIV / 2 - CLK_DIV / 4);
    localparam logic [TW-1:0] T_S1     = TW'(CLK_DIV / 2);
    localparam logic [TW-1:0] T_S2     = TW'(CLK_DIV / 2 + CLK_DIV / 4);
    localparam logic [TW-1:0] T_LAST   = TW'(CLK_DIV - 1);
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t                 state, state_n;
    logic                   rxd_meta, rxd_sync, rxd_prev;
    logic [1:0]             sync_fill;
    logic                   armed;
    logic [TW-1:0]          timer;
    logic                   smp0, smp1;
    logic [DATA_BITS-1:0]   data_sh;
    logic [3:0]             bit_cnt;
    logic                   stop_cnt, stop_err, par_bit;
    logic                   wr_req, brk_q;
    logic [EW-1:0]          wr_entry;
    logic                   fall, at_s2, at_wrap, vote, last_stop, all_zero;
    logic                   par_exp, pe, fe, do_write, do_break;

    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW:0]            wr_cnt, rd_cnt, level;
    logic                   full, push, pop;
    logic [EW-1:0]          head;

    // A start edge is only accepted once the synchroniser has seen a real high
    // level, so a line held low through reset release is not taken as a start bit.
    assign fall      = armed & rxd_prev & ~rxd_sync;
    assign at_s2     = (timer == T_S2);
    assign at_wrap   = (timer == T_LAST);
    assign vote      = (smp0 & smp1) | (smp0 & rxd_sync) | (smp1 & rxd_sync);
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    assign all_zero  = (data_sh == '0) && (PARITY_MODE == 0 || !par_bit) && !vote
                       && (STOP_BITS == 1 || stop_err);

    always_comb begin
        par_exp = 1'b0;
        case (PARITY_MODE)
            1:       par_exp = ~(^data_sh);
            2:       par_exp = ^data_sh;
            3:       par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    assign pe = (PARITY_MODE != 0) && (par_bit != par_exp);
    assign fe = stop_err | ~vote;

    always_comb begin
        state_n  = state;
        do_write = 1'b0;
        do_break = 1'b0;
        case (state)
            IDLE:     if (fall) state_n = START;
            START: begin
                if (at_s2 && vote) state_n = IDLE;
                else if (at_wrap)  state_n = DATA;
            end
            DATA:     if (at_wrap && bit_cnt == BIT_LAST) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            PARITY:   if (at_wrap) state_n = STOP;
            STOP: begin
                // Leaving at S2 of the last stop bit leaves slack for the next start edge.
                if (at_s2 && last_stop) begin
                    if (all_zero) begin
                        do_break = 1'b1;
                        state_n  = BRK_WAIT;
                    end else begin
                        do_write = 1'b1;
                        state_n  = vote ? IDLE : BRK_WAIT;
                    end
                end
            end
            BRK_WAIT: if (rxd_sync) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            rxd_prev  <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
            timer     <= '0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            data_sh   <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            stop_err  <= 1'b0;
            par_bit   <= 1'b0;
            wr_req    <= 1'b0;
            brk_q     <= 1'b0;
            wr_entry  <= '0;
        end else begin
            rxd_meta  <= rxd;
            rxd_sync  <= rxd_meta;
            rxd_prev  <= rxd_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & rxd_sync);
            state     <= state_n;
            wr_req    <= do_write;
            brk_q     <= do_break;
            if (do_write) wr_entry <= {pe, fe, data_sh};
            if (state_n != state || state == IDLE || state == BRK_WAIT || at_wrap) timer <= '0;
            else timer <= timer + 1'b1;
            if (timer == T_S0) smp0 <= rxd_sync;
            if (timer == T_S1) smp1 <= rxd_sync;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    stop_err <= 1'b0;
                end
                DATA: begin
                    if (at_s2)   data_sh <= {vote, data_sh[DATA_BITS-1:1]};
                    if (at_wrap) bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: if (at_s2) par_bit <= vote;
                STOP: if (!last_stop) begin
                    if (at_s2)   stop_err <= ~vote;
                    if (at_wrap) stop_cnt <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign level = wr_cnt - rd_cnt;
    assign full  = (level == DEPTH_L);
    assign pop   = rx_valid & rx_ready;
    assign push  = wr_req & (~full | pop);
    assign head  = mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) wr_cnt <= wr_cnt + 1'b1;
            if (pop)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_cnt[AW-1:0]] <= wr_entry;
    end

    assign rx_valid     = (level != '0);
    assign rx_data      = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign parity_error = rx_valid & head[EW-1];
    assign frame_error  = rx_valid & head[EW-2];
    assign break_det    = brk_q;
    assign overrun      = wr_req & full & ~pop;
    assign fifo_level   = level;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 instance (a) and a 7E2 instance (b), both
// CLK_DIV=16 and FIFO_DEPTH=4, checked against a frame-level reference model.
module tb_uart_rx_ext;
    localparam int CD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_a = 1'b0, rxd_b = 1'b1;
    logic       ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] data_a;
    logic       valid_a, pe_a, fe_a, brk_a, ovr_a;
    logic [2:0] lvl_a;
    logic [6:0] data_b;
    logic       valid_b, pe_b, fe_b, brk_b, ovr_b;
    logic [2:0] lvl_b;

    int total = 0, bad = 0;
    logic [9:0] exp_qa[$];
    logic [8:0] exp_qb[$];
    int pushed_a = 0, pushed_b = 0, pops_a = 0, pops_b = 0;
    int brk_cnt_a = 0, brk_cnt_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;
    int exp_brk_a = 0, exp_ovr_a = 0, exp_ovr_b = 0;
    int max_lvl_a = 0;

    always #5 clk = ~clk;

    uart_rx_ext #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .parity_error(pe_a), .frame_error(fe_a), .break_det(brk_a), .overrun(ovr_a), .fifo_level(lvl_a));

    uart_rx_ext #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .parity_error(pe_b), .frame_error(fe_b), .break_det(brk_b), .overrun(ovr_b), .fifo_level(lvl_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop bits.
    function automatic void build_frame(input int db, input int pmode, input int nstop,
                                        input logic [8:0] d, input bit flip, input bit stop0,
                                        output logic [15:0] bits, output int n);
        int ones = 0;
        logic p;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < db; i++) begin
            bits[1 + i] = d[i];
            if (d[i]) ones++;
        end
        n = 1 + db;
        if (pmode != 0) begin
            case (pmode)
                1:       p = (ones % 2 == 0);
                2:       p = (ones % 2 == 1);
                3:       p = 1'b1;
                default: p = 1'b0;
            endcase
            bits[n] = flip ? ~p : p;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[n] = (s == 0 && stop0) ? 1'b0 : 1'b1;
            n++;
        end
    endfunction

    task automatic set_rxd(input int sel, input logic v);
        if (sel == 0) rxd_a = v;
        else          rxd_b = v;
    endtask

    task automatic drive_bit(input int sel, input logic v, input int glitch_at);
        for (int i = 0; i < CD; i++) begin
            @(negedge clk);
            set_rxd(sel, (i == glitch_at) ? ~v : v);
        end
    endtask

    task automatic send(input int sel, input logic [8:0] d, input bit flip, input bit stop0,
                        input int gbit, input int gap);
        logic [15:0] bits;
        int n;
        if (sel == 0) build_frame(8, 0, 1, d, flip, stop0, bits, n);
        else          build_frame(7, 2, 2, d, flip, stop0, bits, n);
        for (int b = 0; b < n; b++) drive_bit(sel, bits[b], (b == gbit) ? 9 : -1);
        if (sel == 0) begin
            if (exp_qa.size() < 4) begin exp_qa.push_back({flip, stop0, d[7:0]}); pushed_a++; end
            else exp_ovr_a++;
        end else begin
            if (exp_qb.size() < 4) begin exp_qb.push_back({flip, stop0, d[6:0]}); pushed_b++; end
            else exp_ovr_b++;
        end
        if (gap > 0) begin
            set_rxd(sel, 1'b1);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input int sel);
        int k = 0;
        while (((sel == 0) ? exp_qa.size() : exp_qb.size()) != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        if (sel == 0) begin
            check("a_drain_valid", valid_a, 0);
            check("a_drain_level", lvl_a, 0);
        end else begin
            check("b_drain_valid", valid_b, 0);
            check("b_drain_level", lvl_b, 0);
        end
    endtask

    task automatic set_ready(input int sel, input logic v);
        @(posedge clk);
        #1;
        if (sel == 0) ready_a = v;
        else          ready_b = v;
    endtask

    // Scoreboard: every pop is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (brk_a) brk_cnt_a++;
            if (brk_b) brk_cnt_b++;
            if (ovr_a) ovr_cnt_a++;
            if (ovr_b) ovr_cnt_b++;
            if (int'(lvl_a) > max_lvl_a) max_lvl_a = int'(lvl_a);
            if (valid_a && ready_a) begin
                if (exp_qa.size() == 0) check("a_pop_unexpected", valid_a, 0);
                else begin check("a_pop", {pe_a, fe_a, data_a}, exp_qa.pop_front()); pops_a++; end
            end
            if (valid_b && ready_b) begin
                if (exp_qb.size() == 0) check("b_pop_unexpected", valid_b, 0);
                else begin check("b_pop", {pe_b, fe_b, data_b}, exp_qb.pop_front()); pops_b++; end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid_a", valid_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_level_a", lvl_a, 0);
        check("rst_flags_a", {pe_a, fe_a, brk_a, ovr_a}, 0);
        check("rst_valid_b", valid_b, 0);
        check("rst_level_b", lvl_b, 0);
        rst = 1'b0;

        // Line held low through reset release must not start a frame.
        repeat (200) @(negedge clk);
        check("a_low_release_brk", brk_cnt_a, 0);
        check("a_low_release_level", lvl_a, 0);
        rxd_a = 1'b1;
        repeat (20) @(negedge clk);

        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        max_lvl_a = 0;
        send(0, 9'hA5, 0, 0, -1, 0);
        send(0, 9'h3C, 0, 0, -1, 20);
        wait_drain(0);
        check("a_b2b_max_level", max_lvl_a, 1);
        check("a_b2b_no_brk", brk_cnt_a, 0);

        send(0, 9'h00, 0, 0, -1, 16);
        send(0, 9'hFF, 0, 0, -1, 0);
        send(0, 9'h81, 0, 1, -1, 40);
        wait_drain(0);

        // Four-clock low pulse on an idle line is a false start.
        rxd_a = 1'b0;
        repeat (4) @(negedge clk);
        rxd_a = 1'b1;
        repeat (60) @(negedge clk);
        check("a_false_start_level", lvl_a, 0);
        check("a_false_start_brk", brk_cnt_a, 0);

        send(0, 9'h5A, 0, 0, 3, 16);
        send(0, 9'hC3, 0, 0, 0, 16);
        for (int i = 0; i < 16; i++) begin
            send(0, 9'($urandom_range(0, 255)), 0, 0,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1,
                 int'($urandom_range(0, 12)));
        end
        wait_drain(0);

        // Line low for 15 bit times: one break, nothing written.
        exp_brk_a++;
        rxd_a = 1'b0;
        repeat (15 * CD) @(negedge clk);
        rxd_a = 1'b1;
        repeat (40) @(negedge clk);
        check("a_break_count", brk_cnt_a, exp_brk_a);
        check("a_break_level", lvl_a, 0);
        send(0, 9'h55, 0, 0, -1, 20);
        wait_drain(0);

        send(1, 9'h41, 1, 0, -1, 10);
        send(1, 9'h41, 0, 1, -1, 10);
        for (int i = 0; i < 10; i++) begin
            send(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1,
                 int'($urandom_range(0, 10)));
        end
        wait_drain(1);
        check("b_no_brk", brk_cnt_b, 0);
        check("b_no_ovr", ovr_cnt_b, 0);

        set_ready(0, 1'b0);
        for (int i = 0; i < 5; i++) send(0, 9'(8'h10 + 8'(i)), 0, 0, -1, 2);
        repeat (10) @(negedge clk);
        check("a_full_level", lvl_a, 4);
        check("a_full_valid", valid_a, 1);
        check("a_overrun_count", ovr_cnt_a, exp_ovr_a);
        set_ready(0, 1'b1);
        wait_drain(0);

        // Asynchronous reset mid-DATA with two entries queued.
        set_ready(0, 1'b0);
        send(0, 9'h11, 0, 0, -1, 4);
        send(0, 9'h22, 0, 0, -1, 4);
        repeat (4) @(negedge clk);
        check("a_queued_level", lvl_a, 2);
        drive_bit(0, 1'b0, -1);
        repeat (3) drive_bit(0, 1'b1, -1);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid_a", valid_a, 0);
        check("mid_rst_data_a", data_a, 0);
        check("mid_rst_level_a", lvl_a, 0);
        check("mid_rst_flags_a", {pe_a, fe_a, brk_a, ovr_a}, 0);
        exp_qa.delete();
        pushed_a -= 2;
        rxd_a = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        set_ready(0, 1'b1);
        send(0, 9'h9C, 0, 0, -1, 20);
        wait_drain(0);

        check("a_total_pops", pops_a, pushed_a);
        check("b_total_pops", pops_b, pushed_b);
        check("a_total_brk", brk_cnt_a, exp_brk_a);
        check("a_total_ovr", ovr_cnt_a, exp_ovr_a);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
